// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one MAC transmit byte stream between two sources,
// with a programmable inter-frame gap and forced abort of over-length frames.
module mac_tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_FRAME  = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rdy0,
    output logic        rdy1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic        sop0,
    input  logic        sop1,
    input  logic        eop0,
    input  logic        eop1,
    input  logic        err0,
    input  logic        err1,
    input  logic        wren0,
    input  logic        wren1,
    output logic [7:0]  tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_err,
    output logic        tx_wren,
    input  logic        tx_rdy,
    output logic        busy,
    output logic [15:0] abort_cnt
);

    typedef enum logic [1:0] {StIdle, StGrant, StAbort, StGap} state_e;

    localparam logic [7:0]  GapLoad = 8'(GAP_CYCLES);
    localparam logic [16:0] MaxLen  = 17'(MAX_FRAME);

    state_e      state_q, state_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        rr_q, rr_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;
    logic        beat, beat_eop;
    logic [16:0] byte_cnt_inc;

    always_comb begin
        beat         = ((gnt0_q & wren0) | (gnt1_q & wren1)) & tx_rdy;
        beat_eop     = beat & (gnt0_q ? eop0 : eop1);
        byte_cnt_inc = {1'b0, byte_cnt_q} + 17'd1;
    end

    always_comb begin
        state_d     = state_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        rr_d        = rr_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        abort_cnt_d = abort_cnt_q;
        unique case (state_q)
            StIdle: begin
                // rr_q == 0 favours port 0 when both are requesting
                if (req0 && (!req1 || !rr_q)) begin
                    gnt0_d     = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = StGrant;
                end else if (req1) begin
                    gnt1_d     = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (beat) begin
                    byte_cnt_d = byte_cnt_inc[15:0];
                    if (beat_eop) begin
                        gnt0_d    = 1'b0;
                        gnt1_d    = 1'b0;
                        rr_d      = gnt0_q;
                        gap_cnt_d = GapLoad;
                        state_d   = StGap;
                    end else if (byte_cnt_inc == MaxLen) begin
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                        rr_d    = gnt0_q;
                        state_d = StAbort;
                    end
                end
            end
            StAbort: begin
                if (tx_rdy) begin
                    gap_cnt_d = GapLoad;
                    state_d   = StGap;
                    if (abort_cnt_q != 16'hFFFF) begin
                        abort_cnt_d = abort_cnt_q + 16'd1;
                    end
                end
            end
            StGap: begin
                // Leaving on the last count keeps exactly GAP_CYCLES cycles in this state
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rr_q        <= 1'b0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rr_q        <= rr_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        tx_sop  = 1'b0;
        tx_eop  = 1'b0;
        tx_err  = 1'b0;
        tx_wren = 1'b0;
        if (state_q == StAbort) begin
            tx_wren = 1'b1;
            tx_eop  = 1'b1;
            tx_err  = 1'b1;
        end else if (gnt0_q) begin
            tx_data = data0;
            tx_sop  = sop0;
            tx_eop  = eop0;
            tx_err  = err0;
            tx_wren = wren0;
        end else if (gnt1_q) begin
            tx_data = data1;
            tx_sop  = sop1;
            tx_eop  = eop1;
            tx_err  = err1;
            tx_wren = wren1;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rdy0      = tx_rdy & gnt0_q & (state_q != StAbort);
    assign rdy1      = tx_rdy & gnt1_q & (state_q != StAbort);
    assign busy      = (state_q != StIdle);
    assign abort_cnt = abort_cnt_q;

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Shares the single MAC transmit byte interface between two frame sources: port 0 (IQ packetizer) and port 1 (control/status frames).
- Arbitration is frame-granular and round-robin.
- Enforces a programmable idle gap between frames.
- Aborts any frame that exceeds a maximum length. Sits between the sources and the MAC, in the tx_clk domain.

Parameters:
GAP_CYCLES, 16, idle cycles in GAP state after each frame end (1..255)
MAX_FRAME, 1536, accepted bytes per grant before forced abort (range 64..65535)

Ports:
clk  in  1  system clock; also MAC tx_clk
rst  in  1  synchronous, active-high reset
req0  in  1  port 0 has a frame pending; held until its grant
req1  in  1  port 1 has a frame pending
gnt0  out  1  port 0 owns MAC interface
gnt1  out  1  port 1 owns MAC interface
rdy0  out  1  tx_rdy & gnt0 & ~abort
rdy1  out  1  tx_rdy & gnt1 & ~abort
data0/data1  in  8  source bytes
sop0/sop1, eop0/eop1, err0/err1, wren0/wren1  in  1 each  source framing strobes
tx_data  out  8  to MAC
tx_sop, tx_eop, tx_err, tx_wren  out  1  to MAC
tx_rdy  in  1  MAC accepts byte when tx_wren & tx_rdy
busy  out  1  state != IDLE
abort_cnt  out  16  count of forced aborts, saturating

Behaviour:
- States: IDLE, GRANT, ABORT, GAP. Reset: state IDLE, gnt0=gnt1=0, rr pointer=0 (port 0 preferred), byte count=0, gap count=0, abort_cnt=0, all tx_* outputs 0.
- Output mux is combinational from registered gnt:
  - gnt0: tx_* = port 0 signals.
  - gnt1: tx_* = port 1 signals.
  - No grant: tx_* = 0.
  - In ABORT, outputs are overridden.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port selected by the rr pointer.
  - gnt rises on the edge after req is sampled, giving 1-cycle grant latency. State goes to GRANT.
- GRANT:
  - Byte count increments on every accepted beat (wren & tx_rdy from the granted port).
  - Accepted beat with eop: gnt drops the next cycle; rr pointer = other port; state goes to GAP and the gap counter loads GAP_CYCLES.
  - Requester's err is passed through unchanged.
  - sop/eop/wren from the non-granted port are ignored and never reach the MAC.
- Abort:
  - Trigger: byte count reaches MAX_FRAME with no eop accepted.
  - State goes to ABORT; gnt drops; rdyN stays 0.
  - In ABORT, drive tx_wren=1, tx_eop=1, tx_err=1, tx_data=0 until tx_rdy is seen. Then go to GAP and increment abort_cnt (saturating at FFFF).
- GAP:
  - Counter decrements each cycle; at 0, go to IDLE.
  - Requests raised during GAP are held, not lost.
  - GAP_CYCLES=16 gives 17 cycles from the eop beat to the earliest next gnt.
- Beat with eop and byte count == MAX_FRAME in the same cycle: treat as a normal frame end, no abort.
- tx_rdy low in GRANT: no count, no state change; stalls are unbounded.
- req dropped while granted: grant held until eop or abort (the source must finish its frame).
- Reset asserted mid-frame: on the next edge all outputs go 0 and state goes to IDLE. The MAC sees a truncated frame; no abort signalling is generated.
- busy = (state != IDLE).

Test Plan:
- Only req0 high, 100-byte frame with tx_rdy=1: gnt0 one cycle after req0; 100 bytes appear on tx_data in order; gnt0 low the cycle after the eop beat; next gnt no earlier than 17 cycles after eop.
- req0 and req1 high at the same time after reset: port 0 granted first; after its eop and the gap, port 1 is granted; alternation continues for 4 frames (0,1,0,1).
- Port 1 drives sop/wren while port 0 is granted: tx_sop/tx_wren show only port 0 activity; port 1's bytes are never forwarded.
- MAX_FRAME=64, source sends 70 bytes with no eop: after the 64th accepted beat, ABORT drives tx_eop=tx_err=tx_wren=1; abort_cnt becomes 1; gnt deasserted; next frame granted after the gap.
- tx_rdy toggles 50% during a granted frame: accepted-byte count and data order are preserved; rdy0 mirrors tx_rdy; no abort for a 1500-byte frame with MAX_FRAME=1536.
- rst pulsed for 1 cycle mid-frame at byte 20: all tx_* and gnt outputs 0 on the following cycle; busy=0; abort_cnt=0; a fresh req0 is granted normally.
